// File: rtl/calc3_pkg.sv
// Shared types and constants for the calc3 four-port register-file calculator.
package calc3_pkg;

    localparam int NUM_PORTS = 4;
    localparam int NUM_REGS  = 16;
    localparam int QDEPTH    = 4;
    localparam int PTR_W     = $clog2(NUM_PORTS);

    localparam logic [3:0] CMD_NOP   = 4'd0;
    localparam logic [3:0] CMD_ADD   = 4'd1;
    localparam logic [3:0] CMD_SUB   = 4'd2;
    localparam logic [3:0] CMD_SHL   = 4'd5;
    localparam logic [3:0] CMD_SHR   = 4'd6;
    localparam logic [3:0] CMD_STORE = 4'd9;
    localparam logic [3:0] CMD_FETCH = 4'd10;
    localparam logic [3:0] CMD_BZ    = 4'd12;
    localparam logic [3:0] CMD_BEQ   = 4'd13;

    localparam logic [1:0] RESP_NONE = 2'b00;
    localparam logic [1:0] RESP_OK   = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b10;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [3:0]  d1;
        logic [3:0]  d2;
        logic [3:0]  r1;
        logic [1:0]  tag;
        logic [31:0] data;
    } cmd_entry_t;

endpackage

// File: rtl/calc3_port_queue.sv
// Per-port command FIFO; a push arriving while full is silently dropped.
module calc3_port_queue
    import calc3_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  cmd_entry_t push_entry,
    input  logic       pop,
    output logic       empty,
    output cmd_entry_t head
);

    localparam int AW = $clog2(QDEPTH);

    cmd_entry_t    mem [QDEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    // Fullness is judged before this edge's pop, so a full queue drops even when popping.
    assign do_push = push && (count != (AW+1)'(QDEPTH));
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/calc3_top.sv
// Four-port register-file calculator: per-port queues, round-robin arbiter,
// single-issue ALU and 16x32 register file.
module calc3_top
    import calc3_pkg::*;
(
    input  logic        c_clk,
    input  logic        reset,
    input  logic        a_clk,
    input  logic        b_clk,
    input  logic        scan_in,
    output logic        scan_out,
    input  logic [0:3]  req1_cmd, req1_d1, req1_d2, req1_r1,
    input  logic [0:1]  req1_tag,
    input  logic [0:31] req1_data,
    input  logic [0:3]  req2_cmd, req2_d1, req2_d2, req2_r1,
    input  logic [0:1]  req2_tag,
    input  logic [0:31] req2_data,
    input  logic [0:3]  req3_cmd, req3_d1, req3_d2, req3_r1,
    input  logic [0:1]  req3_tag,
    input  logic [0:31] req3_data,
    input  logic [0:3]  req4_cmd, req4_d1, req4_d2, req4_r1,
    input  logic [0:1]  req4_tag,
    input  logic [0:31] req4_data,
    output logic [0:1]  out1_resp, out1_tag,
    output logic [0:31] out1_data,
    output logic [0:1]  out2_resp, out2_tag,
    output logic [0:31] out2_data,
    output logic [0:1]  out3_resp, out3_tag,
    output logic [0:31] out3_data,
    output logic [0:1]  out4_resp, out4_tag,
    output logic [0:31] out4_data
);

    cmd_entry_t                      req_e  [NUM_PORTS];
    cmd_entry_t                      q_head [NUM_PORTS];
    logic [NUM_PORTS-1:0]            q_empty, q_push, q_pop;
    logic [PTR_W-1:0]                ptr, gnt;
    logic                            gnt_vld;
    cmd_entry_t                      cur;
    logic [NUM_REGS-1:0][31:0]       rf;
    logic [31:0]                     ra, rb, wr_val, res_data;
    logic [32:0]                     sum;
    logic [1:0]                      res_resp;
    logic                            wr_en;
    logic [NUM_PORTS-1:0][1:0]       resp_q, tag_q;
    logic [NUM_PORTS-1:0][31:0]      data_q;
    logic                            unused_scan;

    assign scan_out    = 1'b0;
    assign unused_scan = a_clk ^ b_clk ^ scan_in;

    assign req_e[0] = {req1_cmd, req1_d1, req1_d2, req1_r1, req1_tag, req1_data};
    assign req_e[1] = {req2_cmd, req2_d1, req2_d2, req2_r1, req2_tag, req2_data};
    assign req_e[2] = {req3_cmd, req3_d1, req3_d2, req3_r1, req3_tag, req3_data};
    assign req_e[3] = {req4_cmd, req4_d1, req4_d2, req4_r1, req4_tag, req4_data};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign q_push[p] = (req_e[p].cmd != CMD_NOP);
        assign q_pop[p]  = gnt_vld && (gnt == PTR_W'(p));
        calc3_port_queue u_q (
            .clk        (c_clk),
            .reset      (reset),
            .push       (q_push[p]),
            .push_entry (req_e[p]),
            .pop        (q_pop[p]),
            .empty      (q_empty[p]),
            .head       (q_head[p])
        );
    end

    // ptr holds the highest-priority port; it moves to just past each grant.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = ptr;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!gnt_vld && !q_empty[ptr + PTR_W'(i)]) begin
                gnt_vld = 1'b1;
                gnt     = ptr + PTR_W'(i);
            end
        end
    end

    assign cur = q_head[gnt];
    assign ra  = rf[cur.d1];
    assign rb  = rf[cur.d2];
    assign sum = {1'b0, ra} + {1'b0, rb};

    always_comb begin
        res_resp = RESP_ERR;
        res_data = '0;
        wr_en    = 1'b0;
        wr_val   = '0;
        case (cur.cmd)
            CMD_ADD: if (!sum[32]) begin
                res_resp = RESP_OK; wr_en = 1'b1; wr_val = sum[31:0];
            end
            CMD_SUB: if (rb <= ra) begin
                res_resp = RESP_OK; wr_en = 1'b1; wr_val = ra - rb;
            end
            CMD_SHL: begin
                res_resp = RESP_OK; wr_en = 1'b1; wr_val = ra << rb[4:0];
            end
            CMD_SHR: begin
                res_resp = RESP_OK; wr_en = 1'b1; wr_val = ra >> rb[4:0];
            end
            CMD_STORE: begin
                res_resp = RESP_OK; wr_en = 1'b1; wr_val = cur.data;
            end
            CMD_FETCH: begin
                res_resp = RESP_OK; res_data = ra;
            end
            CMD_BZ: begin
                res_resp = RESP_OK; res_data = {31'b0, ra == '0};
            end
            CMD_BEQ: begin
                res_resp = RESP_OK; res_data = {31'b0, ra == rb};
            end
            default: res_resp = RESP_ERR;
        endcase
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            rf     <= '0;
            resp_q <= '0;
            tag_q  <= '0;
            data_q <= '0;
            ptr    <= '0;
        end else begin
            // Responses are single-cycle pulses; idle ports fall back to zero.
            resp_q <= '0;
            tag_q  <= '0;
            data_q <= '0;
            if (gnt_vld) begin
                resp_q[gnt] <= res_resp;
                tag_q[gnt]  <= cur.tag;
                data_q[gnt] <= res_data;
                ptr         <= gnt + 1'b1;
                if (wr_en)
                    rf[cur.r1] <= wr_val;
            end
        end
    end

    assign out1_resp = resp_q[0]; assign out1_tag = tag_q[0]; assign out1_data = data_q[0];
    assign out2_resp = resp_q[1]; assign out2_tag = tag_q[1]; assign out2_data = data_q[1];
    assign out3_resp = resp_q[2]; assign out3_tag = tag_q[2]; assign out3_data = data_q[2];
    assign out4_resp = resp_q[3]; assign out4_tag = tag_q[3]; assign out4_data = data_q[3];

endmodule

// File: tb/tb_calc3_top.sv
// Scoreboard bench for calc3_top: expectations queued at issue, checked on response.
module tb_calc3_top;

    logic        c_clk = 1'b0, reset = 1'b1, a_clk = 1'b0, b_clk = 1'b0, scan_in = 1'b0;
    logic        scan_out;
    logic [3:0]  cmd [4], d1 [4], d2 [4], r1 [4];
    logic [1:0]  tg [4];
    logic [31:0] dat [4];
    logic [1:0]  o_resp [4], o_tag [4];
    logic [31:0] o_data [4];

    typedef struct {
        logic [1:0]  tag;
        logic [1:0]  resp;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb [4][$];
    logic [31:0] rm [16];
    int          cyc = 0;
    int          n_checks = 0, n_errors = 0;

    calc3_top dut (
        .c_clk(c_clk), .reset(reset), .a_clk(a_clk), .b_clk(b_clk),
        .scan_in(scan_in), .scan_out(scan_out),
        .req1_cmd(cmd[0]), .req1_d1(d1[0]), .req1_d2(d2[0]), .req1_r1(r1[0]), .req1_tag(tg[0]), .req1_data(dat[0]),
        .req2_cmd(cmd[1]), .req2_d1(d1[1]), .req2_d2(d2[1]), .req2_r1(r1[1]), .req2_tag(tg[1]), .req2_data(dat[1]),
        .req3_cmd(cmd[2]), .req3_d1(d1[2]), .req3_d2(d2[2]), .req3_r1(r1[2]), .req3_tag(tg[2]), .req3_data(dat[2]),
        .req4_cmd(cmd[3]), .req4_d1(d1[3]), .req4_d2(d2[3]), .req4_r1(r1[3]), .req4_tag(tg[3]), .req4_data(dat[3]),
        .out1_resp(o_resp[0]), .out1_tag(o_tag[0]), .out1_data(o_data[0]),
        .out2_resp(o_resp[1]), .out2_tag(o_tag[1]), .out2_data(o_data[1]),
        .out3_resp(o_resp[2]), .out3_tag(o_tag[2]), .out3_data(o_data[2]),
        .out4_resp(o_resp[3]), .out4_tag(o_tag[3]), .out4_data(o_data[3])
    );

    always #5 c_clk = ~c_clk;
    always @(posedge c_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Response monitor: every nonzero resp must match the oldest expectation of its port.
    always @(negedge c_clk) begin
        exp_t e;
        if (!reset) begin
            for (int p = 0; p < 4; p++) begin
                if (o_resp[p] != 2'b00) begin
                    if (sb[p].size() == 0) begin
                        chk($sformatf("p%0d_spurious", p + 1), 64'(o_resp[p]), 64'd0);
                    end else begin
                        e = sb[p].pop_front();
                        chk($sformatf("p%0d_tag", p + 1),  64'(o_tag[p]),  64'(e.tag));
                        chk($sformatf("p%0d_resp", p + 1), 64'(o_resp[p]), 64'(e.resp));
                        chk($sformatf("p%0d_data", p + 1), 64'(o_data[p]), 64'(e.data));
                        chk($sformatf("p%0d_cycle", p + 1), 64'(cyc), 64'(e.cyc));
                    end
                end else begin
                    chk($sformatf("p%0d_idle", p + 1), {30'b0, o_tag[p], o_data[p]}, 64'd0);
                end
            end
        end
    end

    task automatic clear_inputs();
        for (int p = 0; p < 4; p++) begin
            cmd[p] = 4'd0; d1[p] = 4'd0; d2[p] = 4'd0; r1[p] = 4'd0; tg[p] = 2'd0; dat[p] = 32'd0;
        end
    endtask

    task automatic tick();
        @(negedge c_clk);
        clear_inputs();
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) rm[i] = 32'd0;
        for (int p = 0; p < 4; p++) sb[p].delete();
    endtask

    // Drive one request on port p this cycle; keep=0 means it must never answer.
    task automatic issue(input int p, input logic [3:0] c, input logic [3:0] a1, input logic [3:0] a2,
                         input logic [3:0] w, input logic [1:0] t, input logic [31:0] v,
                         input int lat, input bit keep);
        logic [31:0] x, y;
        logic [32:0] s;
        logic [1:0]  r;
        logic [31:0] od;
        cmd[p] = c; d1[p] = a1; d2[p] = a2; r1[p] = w; tg[p] = t; dat[p] = v;
        if (keep) begin
            x = rm[a1]; y = rm[a2]; r = 2'b01; od = 32'd0;
            case (c)
                4'd1: begin
                    s = {1'b0, x} + {1'b0, y};
                    if (s > 33'h0_FFFF_FFFF) r = 2'b10; else rm[w] = s[31:0];
                end
                4'd2:  if (y > x) r = 2'b10; else rm[w] = x - y;
                4'd5:  rm[w] = x << y[4:0];
                4'd6:  rm[w] = x >> y[4:0];
                4'd9:  rm[w] = v;
                4'd10: od = x;
                4'd12: od = (x == 32'd0) ? 32'd1 : 32'd0;
                4'd13: od = (x == y) ? 32'd1 : 32'd0;
                default: r = 2'b10;
            endcase
            sb[p].push_back('{tag: t, resp: r, data: od, cyc: cyc + lat});
        end
    endtask

    task automatic wait_idle();
        int left;
        left = sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size();
        for (int i = 0; i < 40 && left != 0; i++) begin
            tick();
            left = sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size();
        end
        chk("drain_outstanding", 64'(left), 64'd0);
        tick();
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        clear_model();
    endtask

    initial begin
        clear_inputs();
        clear_model();
        @(negedge c_clk);
        do_reset();
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("rst_p%0d_resp", p + 1), 64'(o_resp[p]), 64'd0);
            chk($sformatf("rst_p%0d_out", p + 1), {30'b0, o_tag[p], o_data[p]}, 64'd0);
        end
        chk("scan_out", 64'(scan_out), 64'd0);

        // FETCH from a freshly reset register
        issue(0, 4'd10, 4'd1, 4'd0, 4'd0, 2'd1, 32'd0, 2, 1); tick();
        wait_idle();

        // STORE then FETCH on port 2
        issue(1, 4'd9, 4'd0, 4'd0, 4'd3, 2'd2, 32'h0000_0005, 2, 1); tick();
        issue(1, 4'd10, 4'd3, 4'd0, 4'd0, 2'd3, 32'd0, 2, 1); tick();
        wait_idle();

        // ADD overflow, SUB underflow, good SUB
        issue(0, 4'd9,  4'd0, 4'd0, 4'd1, 2'd0, 32'hFFFF_FFFF, 2, 1); tick();
        issue(0, 4'd9,  4'd0, 4'd0, 4'd2, 2'd1, 32'h0000_0001, 2, 1); tick();
        issue(0, 4'd1,  4'd1, 4'd2, 4'd4, 2'd2, 32'd0, 2, 1); tick();
        issue(0, 4'd10, 4'd4, 4'd0, 4'd0, 2'd3, 32'd0, 2, 1); tick();
        issue(0, 4'd2,  4'd2, 4'd1, 4'd4, 2'd0, 32'd0, 2, 1); tick();
        issue(0, 4'd2,  4'd1, 4'd2, 4'd4, 2'd1, 32'd0, 2, 1); tick();
        issue(0, 4'd10, 4'd4, 4'd0, 4'd0, 2'd2, 32'd0, 2, 1); tick();
        wait_idle();

        // Shifts with amount taken from low 5 bits, compares, invalid opcode, plain ADD
        issue(0, 4'd9,  4'd0, 4'd0, 4'd1, 2'd0, 32'h8000_0001, 2, 1); tick();
        issue(0, 4'd9,  4'd0, 4'd0, 4'd2, 2'd1, 32'd33, 2, 1); tick();
        issue(0, 4'd5,  4'd1, 4'd2, 4'd5, 2'd2, 32'd0, 2, 1); tick();
        issue(0, 4'd10, 4'd5, 4'd0, 4'd0, 2'd3, 32'd0, 2, 1); tick();
        issue(0, 4'd6,  4'd1, 4'd2, 4'd5, 2'd0, 32'd0, 2, 1); tick();
        issue(0, 4'd10, 4'd5, 4'd0, 4'd0, 2'd1, 32'd0, 2, 1); tick();
        issue(0, 4'd7,  4'd1, 4'd2, 4'd6, 2'd2, 32'd0, 2, 1); tick();
        issue(0, 4'd12, 4'd0, 4'd0, 4'd0, 2'd3, 32'd0, 2, 1); tick();
        issue(0, 4'd12, 4'd1, 4'd0, 4'd0, 2'd0, 32'd0, 2, 1); tick();
        issue(0, 4'd13, 4'd1, 4'd1, 4'd0, 2'd1, 32'd0, 2, 1); tick();
        issue(0, 4'd13, 4'd1, 4'd2, 4'd0, 2'd2, 32'd0, 2, 1); tick();
        issue(0, 4'd1,  4'd1, 4'd2, 4'd0, 2'd3, 32'd0, 2, 1); tick();
        issue(0, 4'd10, 4'd0, 4'd0, 4'd0, 2'd0, 32'd0, 2, 1); tick();
        wait_idle();

        // Reset while a STORE is queued: it must vanish and R7 read back 0
        issue(0, 4'd9, 4'd0, 4'd0, 4'd7, 2'd0, 32'h0000_1234, 2, 0); tick();
        reset = 1'b1; tick();
        reset = 1'b0; clear_model();
        issue(0, 4'd10, 4'd7, 4'd0, 4'd0, 2'd1, 32'd0, 2, 1); tick();
        wait_idle();

        // Preload through port 4 so the pointer wraps back to port 1
        for (int i = 1; i <= 4; i++) begin
            issue(3, 4'd9, 4'd0, 4'd0, 4'(i), 2'(i), 32'h1111_0000 * i + 32'(i), 2, 1); tick();
        end
        wait_idle();

        // Simultaneous FETCH on all ports: round-robin from port 1
        issue(0, 4'd10, 4'd1, 4'd0, 4'd0, 2'd1, 32'd0, 2, 1);
        issue(1, 4'd10, 4'd2, 4'd0, 4'd0, 2'd2, 32'd0, 3, 1);
        issue(2, 4'd10, 4'd3, 4'd0, 4'd0, 2'd3, 32'd0, 4, 1);
        issue(3, 4'd10, 4'd4, 4'd0, 4'd0, 2'd0, 32'd0, 5, 1);
        tick();
        wait_idle();

        // Single port-3 command leaves port 4 as next priority
        issue(2, 4'd10, 4'd3, 4'd0, 4'd0, 2'd1, 32'd0, 2, 1); tick();
        wait_idle();

        // Port 3 fills while ports 4,1,2 are served first; its 5th command is dropped
        issue(2, 4'd10, 4'd1, 4'd0, 4'd0, 2'd0, 32'd0, 5, 1);
        issue(3, 4'd10, 4'd2, 4'd0, 4'd0, 2'd1, 32'd0, 2, 1);
        issue(0, 4'd10, 4'd3, 4'd0, 4'd0, 2'd2, 32'd0, 3, 1);
        issue(1, 4'd10, 4'd4, 4'd0, 4'd0, 2'd3, 32'd0, 4, 1);
        tick();
        issue(2, 4'd10, 4'd2, 4'd0, 4'd0, 2'd1, 32'd0, 5, 1); tick();
        issue(2, 4'd10, 4'd3, 4'd0, 4'd0, 2'd2, 32'd0, 5, 1); tick();
        issue(2, 4'd10, 4'd4, 4'd0, 4'd0, 2'd3, 32'd0, 5, 1); tick();
        issue(2, 4'd9,  4'd0, 4'd0, 4'd9, 2'd0, 32'hDEAD_BEEF, 2, 0); tick();
        wait_idle();
        issue(0, 4'd10, 4'd9, 4'd0, 4'd0, 2'd0, 32'd0, 2, 1); tick();
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
